// File: rtl/sm_pkg.sv
// Shared state encoding, output decode and transition rules for the sm_para_1 FSM.
// Pure declarations and functions; no latency of its own.
// No flow control; consumers call the functions combinationally.
package sm_pkg;

    // One-hot state codes
    localparam logic [3:0] IDLE  = 4'b0001;
    localparam logic [3:0] S1    = 4'b0010;
    localparam logic [3:0] S2    = 4'b0100;
    localparam logic [3:0] ERROR = 4'b1000;

    // Output decode constants, ordered {o1, o2, err}
    localparam logic [2:0] OUT_IDLE  = 3'b000;
    localparam logic [2:0] OUT_S1    = 3'b100;
    localparam logic [2:0] OUT_S2    = 3'b010;
    localparam logic [2:0] OUT_ERROR = 3'b111;

    // Next-state rule; non-one-hot codes fall back to IDLE
    function automatic logic [3:0] sm_next(input logic [3:0] s, input logic a, input logic b);
        logic [3:0] n;
        n = IDLE;
        case (s)
            IDLE: begin
                if (!a)     n = IDLE;
                else if (b) n = S1;
                else        n = ERROR;
            end
            S1: begin
                if (!b)     n = S1;
                else if (a) n = S2;
                else        n = ERROR;
            end
            S2: begin
                if (b)      n = S2;
                else if (a) n = IDLE;
                else        n = ERROR;
            end
            ERROR: begin
                if (a)      n = ERROR;
                else        n = IDLE;
            end
            default:        n = IDLE;
        endcase
        return n;
    endfunction

    // Moore decode of a state code into {o1, o2, err}
    function automatic logic [2:0] sm_decode(input logic [3:0] s);
        logic [2:0] d;
        d = OUT_IDLE;
        case (s)
            IDLE:    d = OUT_IDLE;
            S1:      d = OUT_S1;
            S2:      d = OUT_S2;
            ERROR:   d = OUT_ERROR;
            default: d = OUT_IDLE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sm_para_1.sv
// Four-state one-hot Moore control FSM (IDLE/S1/S2/ERROR) with registered outputs.
// Outputs change on the same edge as the state; no input-to-output combinational path.
// No backpressure; i1/i2 are sampled every rising edge, ERROR holds while i1=1.
module sm_para_1
    import sm_pkg::*;
(
    input  logic clk,
    input  logic nrst,   // active-high asynchronous reset despite the name
    input  logic i1,
    input  logic i2,
    output logic o1,
    output logic o2,
    output logic err
);

    logic [3:0] state_q;
    logic [3:0] state_d;

    assign state_d = sm_next(state_q, i1, i2);

    // State and outputs share one clocked block; outputs register the decode of
    // the state being entered so they always match the current state.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q <= IDLE;
            o1      <= 1'b0;
            o2      <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q         <= state_d;
            {o1, o2, err}   <= sm_decode(state_d);
        end
    end

endmodule

// File: tb/tb_sm_para_1.sv
// Self-checking bench for sm_para_1 against an abstract transition-table model.
module tb_sm_para_1;

    logic clk;
    logic nrst;
    logic i1;
    logic i2;
    logic o1;
    logic o2;
    logic err;

    int errors = 0;
    int checks = 0;

    // Model state: 0=IDLE 1=S1 2=S2 3=ERROR
    int ms;
    int visited [4];

    sm_para_1 dut (
        .clk  (clk),
        .nrst (nrst),
        .i1   (i1),
        .i2   (i2),
        .o1   (o1),
        .o2   (o2),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {o1,o2,err} per model state
    function automatic logic [2:0] exp_out(input int s);
        case (s)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Transition table straight from the rules: rows by state, pick by inputs
    function automatic int model_next(input int s, input bit a, input bit b);
        int tbl [4][4];
        // index = {a,b}: 0=(0,0) 1=(0,1) 2=(1,0) 3=(1,1)
        tbl[0] = '{0, 0, 3, 1};
        tbl[1] = '{1, 3, 1, 2};
        tbl[2] = '{3, 2, 0, 2};
        tbl[3] = '{0, 0, 3, 3};
        return tbl[s][{a, b}];
    endfunction

    // Apply inputs, clock once, update model, sample 1 time unit after the edge
    task automatic step(input bit a, input bit b);
        i1 = a;
        i2 = b;
        @(posedge clk);
        ms = model_next(ms, a, b);
        visited[ms]++;
        #1;
    endtask

    task automatic test_reset;
        nrst = 1'b1;
        i1 = 1'b0;
        i2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o1, o2, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got %b want 000", {o1, o2, err});
        end
        nrst = 1'b0;
        ms = 0;
        step(1'b0, 1'b0);
        checks++;
        if ({o1, o2, err} !== exp_out(ms)) begin
            errors++;
            $display("FAIL reset_release_idle: got %b want %b", {o1, o2, err}, exp_out(ms));
        end
    endtask

    task automatic test_sequence;
        bit [1:0] seq [4];
        logic [2:0] want [4];
        seq  = '{2'b11, 2'b11, 2'b01, 2'b10};
        want = '{3'b100, 3'b010, 3'b010, 3'b000};
        for (int k = 0; k < 4; k++) begin
            step(seq[k][1], seq[k][0]);
            checks++;
            if ({o1, o2, err} !== want[k] || {o1, o2, err} !== exp_out(ms)) begin
                errors++;
                $display("FAIL sequence_step%0d: got %b want %b", k, {o1, o2, err}, want[k]);
            end
        end
    endtask

    task automatic test_errors;
        // IDLE -> ERROR
        step(1'b1, 1'b0);
        checks++;
        if ({o1, o2, err} !== 3'b111) begin
            errors++;
            $display("FAIL err_from_idle: got %b want 111", {o1, o2, err});
        end
        step(1'b0, 1'b0);
        // S1 -> ERROR
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if ({o1, o2, err} !== 3'b111) begin
            errors++;
            $display("FAIL err_from_s1: got %b want 111", {o1, o2, err});
        end
        step(1'b0, 1'b0);
        // S2 -> ERROR
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        checks++;
        if ({o1, o2, err} !== 3'b111) begin
            errors++;
            $display("FAIL err_from_s2: got %b want 111", {o1, o2, err});
        end
    endtask

    task automatic test_error_hold;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'(k & 1));
            checks++;
            if (err !== 1'b1 || {o1, o2, err} !== exp_out(ms)) begin
                errors++;
                $display("FAIL err_hold%0d: got %b want 111", k, {o1, o2, err});
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if ({o1, o2, err} !== 3'b000) begin
            errors++;
            $display("FAIL err_exit: got %b want 000", {o1, o2, err});
        end
    endtask

    task automatic test_hold;
        step(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'(k & 1), 1'b0);
            checks++;
            if ({o1, o2, err} !== 3'b100) begin
                errors++;
                $display("FAIL s1_hold%0d: got %b want 100", k, {o1, o2, err});
            end
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'(k & 1));
            checks++;
            if ({o1, o2, err} !== 3'b000) begin
                errors++;
                $display("FAIL idle_hold%0d: got %b want 000", k, {o1, o2, err});
            end
        end
    endtask

    task automatic test_async_reset;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if ({o1, o2, err} !== 3'b010) begin
            errors++;
            $display("FAIL pre_reset_s2: got %b want 010", {o1, o2, err});
        end
        #2;
        nrst = 1'b1;
        #1;
        checks++;
        if ({o1, o2, err} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got %b want 000", {o1, o2, err});
        end
        i1 = 1'b1;
        i2 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({o1, o2, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_held: got %b want 000", {o1, o2, err});
        end
        @(negedge clk);
        nrst = 1'b0;
        ms = 0;
        step(1'b0, 1'b1);
        checks++;
        if ({o1, o2, err} !== 3'b000) begin
            errors++;
            $display("FAIL after_reset_idle: got %b want 000", {o1, o2, err});
        end
    endtask

    task automatic test_random;
        for (int s = 0; s < 4; s++) visited[s] = 0;
        for (int k = 0; k < 1500; k++) begin
            step(1'($urandom_range(1)), 1'($urandom_range(1)));
            checks++;
            if ({o1, o2, err} !== exp_out(ms)) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b want %b", k, {o1, o2, err}, exp_out(ms));
            end
        end
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (visited[s] == 0) begin
                errors++;
                $display("FAIL coverage_state%0d: visits %0d want >0", s, visited[s]);
            end
        end
    endtask

    initial begin
        ms = 0;
        test_reset();
        test_sequence();
        test_errors();
        test_error_hold();
        test_hold();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
